// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM states, sample points, width helpers.
package uart_rx_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  // Three sample points straddling the middle of a 16-tick bit.
  localparam int SAMPLE_FIRST = 7;
  localparam int SAMPLE_MID   = 8;
  localparam int SAMPLE_LAST  = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  // Counter width for a counter running 0..n-1 (same derivation as the baud generator).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Two-out-of-three vote.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial-side inputs and byte-side outputs of the UART receiver.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 Rx_CLK;
  logic                 RxD;
  logic [DATA_BITS-1:0] Rx_Data;
  logic                 Rx_Valid;
  logic                 Frame_Err;
  logic                 Rx_Busy;

  // Drives the line and the sample tick, consumes received bytes.
  modport master (
    output Rx_CLK, RxD,
    input  Rx_Data, Rx_Valid, Frame_Err, Rx_Busy
  );

  // The receiver itself.
  modport slave (
    input  Rx_CLK, RxD,
    output Rx_Data, Rx_Valid, Frame_Err, Rx_Busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Multi-stage synchroniser for the asynchronous RxD line; resets to the idle level (1).
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_d, sync_q;

  // Shift the raw line in at the bottom of the chain.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Chain registers; reset to 1 so a reset never looks like a start bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync_q <= '1;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with 3-sample majority vote, valid and framing-error strobes.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave bus
);

  localparam int CNT_W = cnt_width(OVERSAMPLE);
  localparam int BIT_W = cnt_width(DATA_BITS);

  logic                 rxs;
  logic                 bit_now;
  rx_state_e            state_d, state_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [BIT_W-1:0]     bit_d, bit_q;
  logic [1:0]           vote_d, vote_q;   // samples from counts 7 and 8; count 9 is used live
  logic [DATA_BITS-1:0] shift_d, shift_q;
  logic [DATA_BITS-1:0] data_d, data_q;
  logic                 valid_d, valid_q;
  logic                 ferr_d, ferr_q;
  logic                 busy_d, busy_q;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (bus.RxD),
    .q   (rxs)
  );

  // Next-state logic: everything except strobe deassertion waits for an Rx_CLK tick.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    vote_d  = vote_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    bit_now = maj3({rxs, vote_q});

    if (bus.Rx_CLK) begin
      if (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP) begin
        cnt_d = (cnt_q == CNT_W'(OVERSAMPLE - 1)) ? '0 : cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SAMPLE_FIRST)) vote_d[0] = rxs;
        if (cnt_q == CNT_W'(SAMPLE_MID))   vote_d[1] = rxs;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (!rxs) begin
            state_d = ST_START;
            cnt_d   = '0;
          end
        end
        ST_START: begin
          if (cnt_q == CNT_W'(SAMPLE_LAST)) begin
            if (bit_now) begin
              state_d = ST_IDLE;        // glitch, not a real start bit
            end else begin
              state_d = ST_DATA;
              bit_d   = '0;
            end
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_W'(SAMPLE_LAST)) begin
            shift_d = {bit_now, shift_q[DATA_BITS-1:1]};   // LSB arrives first
            if (bit_q == BIT_W'(DATA_BITS - 1)) state_d = ST_STOP;
            else                                bit_d   = bit_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt_q == CNT_W'(SAMPLE_LAST)) begin
            if (bit_now) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = ST_IDLE;        // mid-stop-bit, so a back-to-back start is caught
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (rxs) state_d = ST_IDLE;   // a held-low break must not restart frames
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: the shift register and byte output are cleared on reset too, so a reset mid-frame leaves no stale data.
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      vote_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      vote_q  <= vote_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.Rx_Data   = data_q;
  assign bus.Rx_Valid  = valid_q;
  assign bus.Frame_Err = ferr_q;
  assign bus.Rx_Busy   = busy_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 16x-oversampling UART receiver, 8N1 by default; the receive-side consumer of the baud generator's Rx_CLK sample tick.
- Synchronises the asynchronous serial line and detects start bits. Majority-votes three mid-bit samples per bit.
- Presents each received byte with a one-cycle valid strobe, or a one-cycle framing-error strobe.
- Sits between the pin-level RxD and the user logic (display, loopback, FIFO).

Parameters:
DATA_BITS, 8, payload bits per frame, LSB first.
OVERSAMPLE, 16, Rx_CLK ticks per bit period; must equal the generator's receive oversample ratio.
SYNC_STAGES, 2, flip-flop stages on RxD before any logic; minimum 2.

Ports:
CLK  input  1  system clock; all state on posedge.
RST  input  1  asynchronous, active-high reset.
Rx_CLK  input  1  one-CLK-wide sample enable at OVERSAMPLE x baud; all FSM and counter activity is gated by it.
RxD  input  1  serial line, idles high, asynchronous to CLK.
Rx_Data  output  DATA_BITS  last correctly framed byte; holds until the next valid frame.
Rx_Valid  output  1  one-CLK pulse: Rx_Data updated this cycle.
Frame_Err  output  1  one-CLK pulse: stop bit sampled low.
Rx_Busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - Synchroniser stages = 1; state = IDLE; tick counter = 0; bit counter = 0; shift register = 0.
  - Rx_Data = 0; Rx_Valid = 0; Frame_Err = 0; Rx_Busy = 0.
  - Reset mid-frame abandons the frame with no strobe.
- Signal naming: rxs = synchronised RxD. tick = Rx_CLK high on a CLK edge. The tick counter runs 0..OVERSAMPLE-1 within a bit and wraps to 0.
- Sampling: on ticks at count 7, 8 and 9, rxs is captured into a 3-bit vote. The bit value is the majority of the three; it is decided on the count-9 tick and includes that tick's sample.
- IDLE:
  - On a tick with rxs = 0: go to START with count = 0.
  - Otherwise stay.
- START:
  - Count advances each tick.
  - At the count-9 decision, majority 0: go to DATA with bit counter = 0.
  - Majority 1 (false start / glitch): go to IDLE with no strobe.
- DATA:
  - At each count-9 decision, shift the majority bit in LSB-first.
  - After bit DATA_BITS-1: go to STOP.
  - The counter wraps at 15, so decisions fall 16 ticks apart.
- STOP:
  - Majority 1: load Rx_Data from the shift register, pulse Rx_Valid, go to IDLE.
  - Majority 0: pulse Frame_Err, leave Rx_Data unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until a tick with rxs = 1, then go to IDLE. This prevents a held-low break from retriggering frames.
- Strobe timing:
  - Rx_Valid and Frame_Err are registered and assert in the CLK cycle after the deciding tick edge, for exactly one CLK.
  - They are never high together.
- Frame boundaries:
  - The stop decision falls mid-stop-bit; returning to IDLE there lets a back-to-back start bit be caught.
  - Latency from the start-bit falling edge to Rx_Valid ≈ (9 + 16 x (DATA_BITS+1)) ticks + SYNC_STAGES + 1 CLK.
- Rx_CLK and RxD are independent: no change occurs between ticks except synchroniser shifting and strobe deassertion.

Decomposition:
- A shared uart package holds:
  - State encoding (IDLE, START, DATA, STOP, WAIT_IDLE).
  - OVERSAMPLE and the sample-point constants 7/8/9.
  - DATA_BITS default.
  - Counter-width derivation via $clog2; the existing baud generator uses the same derivation.
- One natural sub-module: uart_rx_sync, the SYNC_STAGES flip-flop synchroniser with async reset to 1.
- The majority vote stays inline.

Test Plan:
- Byte 0xA5 framed 8N1 at 16 ticks/bit (Rx_CLK every 4 CLK) -> Rx_Valid single pulse, Rx_Data = 0xA5, Frame_Err stays 0, Rx_Busy low afterwards.
- Frames 0x00 then 0xFF back-to-back with a single stop bit -> two Rx_Valid pulses, Rx_Data = 0x00 then 0xFF, no Frame_Err.
- Byte 0x3C with stop bit driven low, then line held low for 40 bit times -> one Frame_Err pulse, Rx_Data keeps its previous value, no further strobes until the line returns high.
- RxD low for 4 ticks only (glitch) -> returns to IDLE at the count-9 decision, no strobes, and a following 0x5A frame is received correctly.
- 0x81 with a single-tick inversion at count 8 of bit 3 -> majority rejects it, Rx_Data = 0x81.
- RST asserted mid-DATA of 0x77, released, then 0x12 sent -> no strobe for 0x77, all outputs 0 during reset, Rx_Data = 0x12 afterwards.
